// File: rtl/i2c_slave_regs_if.sv
// Avalon-MM register-port bundle for i2c_slave_regs; the CPU side is master.
interface i2c_slave_regs_if;
  logic [4:0]  address;
  logic [31:0] readdata;
  logic [31:0] writedata;
  logic        read;
  logic        write;
  logic        waitrequest;

  modport slave  (input address, writedata, read, write, output readdata, waitrequest);
  modport master (output address, writedata, read, write, input readdata, waitrequest);
endinterface

// File: rtl/i2c_slave_regs.sv
// I2C target with a 16x8 register bank shared with an Avalon-MM CPU port.
// No clock stretching; SDA is only ever pulled low, SCL is never driven.
module i2c_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42,
  parameter int         FILTER_LEN = 3
) (
  input  logic              clock,
  input  logic              clock_sreset,
  i2c_slave_regs_if.slave   bus,
  inout  wire               sda,
  inout  wire               scl
);
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  logic [1:0]            scl_sync, sda_sync;
  logic [FILTER_LEN-1:0] scl_hist, sda_hist;
  logic                  scl_f, sda_f, scl_q, sda_q;
  logic                  scl_rise, scl_fall, start_ev, stop_ev;

  state_t            state, state_nxt;
  logic [3:0]        cnt, pointer;
  logic [7:0]        shreg;
  logic              rw, sda_low, sda_nxt;
  logic              shift_in, cnt_inc, cnt_clr, ptr_load, byte_we, rd_load, rd_shift;
  logic              rw_load, nack_set;
  logic [15:0][7:0]  bank;
  logic              wr_event, nack_seen, busy, read_latency;
  logic [31:0]       readdata, rd_mux;
  logic              av_reg_wr, av_stat_wr;
  logic              unused_wdata;

  assign sda = sda_low ? 1'b0 : 1'bz;
  assign scl = 1'bz;

  // Bus idles high, so the conditioning chain resets to 1 to avoid a fake edge.
  always_ff @(posedge clock) begin
    if (clock_sreset) begin
      scl_sync <= '1; sda_sync <= '1;
      scl_hist <= '1; sda_hist <= '1;
      scl_f    <= 1'b1; sda_f <= 1'b1;
      scl_q    <= 1'b1; sda_q <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda};
      scl_hist <= {scl_hist[FILTER_LEN-2:0], scl_sync[1]};
      sda_hist <= {sda_hist[FILTER_LEN-2:0], sda_sync[1]};
      if (&scl_hist) scl_f <= 1'b1; else if (~|scl_hist) scl_f <= 1'b0;
      if (&sda_hist) sda_f <= 1'b1; else if (~|sda_hist) sda_f <= 1'b0;
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  assign scl_rise = scl_f & ~scl_q;
  assign scl_fall = ~scl_f & scl_q;
  assign start_ev = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_ev  = scl_f & scl_q & ~sda_q & sda_f;

  always_comb begin
    state_nxt = state;
    sda_nxt   = sda_low;
    shift_in  = 1'b0; cnt_inc  = 1'b0; cnt_clr = 1'b0;
    ptr_load  = 1'b0; byte_we  = 1'b0; rd_load = 1'b0; rd_shift = 1'b0;
    rw_load   = 1'b0; nack_set = 1'b0;
    if (start_ev) begin
      state_nxt = ADDR; sda_nxt = 1'b0; cnt_clr = 1'b0 | 1'b1;
    end else if (stop_ev) begin
      state_nxt = IDLE; sda_nxt = 1'b0;
    end else begin
      case (state)
        ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            shift_in = 1'b1; cnt_inc = 1'b1;
          end else if (scl_fall && cnt == 4'd8) begin
            cnt_clr = 1'b1;
            sda_nxt = 1'b1;
            if (state == ADDR) begin
              if (shreg[7:1] == SLAVE_ADDR) begin
                state_nxt = ADDR_ACK; rw_load = 1'b1;
              end else begin
                state_nxt = IGNORE; sda_nxt = 1'b0;
              end
            end else if (state == PTR) begin
              state_nxt = PTR_ACK; ptr_load = 1'b1;
            end else begin
              state_nxt = WDATA_ACK; byte_we = 1'b1;
            end
          end
        end
        ADDR_ACK: if (scl_fall) begin
          if (rw) begin
            state_nxt = RDATA; rd_load = 1'b1; sda_nxt = ~bank[pointer][7];
          end else begin
            state_nxt = PTR; sda_nxt = 1'b0;
          end
        end
        PTR_ACK, WDATA_ACK: if (scl_fall) begin
          state_nxt = WDATA; sda_nxt = 1'b0;
        end
        // The MSB went out with the load, so seven more shifts finish the byte.
        RDATA: if (scl_fall) begin
          if (cnt == 4'd7) begin
            state_nxt = RDATA_ACK; sda_nxt = 1'b0; cnt_clr = 1'b1;
          end else begin
            rd_shift = 1'b1; cnt_inc = 1'b1; sda_nxt = ~shreg[6];
          end
        end
        RDATA_ACK: begin
          if (scl_rise && sda_f) begin
            state_nxt = IGNORE; nack_set = 1'b1;
          end else if (scl_fall) begin
            state_nxt = RDATA; rd_load = 1'b1; sda_nxt = ~bank[pointer][7];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (clock_sreset) begin
      state   <= IDLE;
      sda_low <= 1'b0;
      cnt     <= '0;
      shreg   <= '0;
      pointer <= '0;
      rw      <= 1'b0;
    end else begin
      state   <= state_nxt;
      sda_low <= sda_nxt;
      if (cnt_clr | rd_load) cnt <= '0;
      else if (cnt_inc)      cnt <= cnt + 4'd1;
      if (shift_in)      shreg <= {shreg[6:0], sda_f};
      else if (rd_load)  shreg <= bank[pointer];
      else if (rd_shift) shreg <= {shreg[6:0], 1'b0};
      if (rw_load) rw <= shreg[0];
      if (ptr_load)               pointer <= shreg[3:0];
      else if (byte_we | rd_load) pointer <= pointer + 4'd1;
    end
  end

  assign busy       = (state != IDLE) && (state != IGNORE);
  assign av_reg_wr  = bus.write & ~bus.address[4];
  assign av_stat_wr = bus.write & (bus.address == 5'd16);

  always_comb begin
    rd_mux = '0;
    if (!bus.address[4])          rd_mux = {24'b0, bank[bus.address[3:0]]};
    else if (bus.address == 5'd16) rd_mux = {29'b0, nack_seen, wr_event, busy};
  end

  // Avalon write is applied after the I2C write so it wins a same-entry collision.
  always_ff @(posedge clock) begin
    if (clock_sreset) begin
      bank         <= '0;
      wr_event     <= 1'b0;
      nack_seen    <= 1'b0;
      readdata     <= '0;
      read_latency <= 1'b0;
    end else begin
      if (byte_we)   bank[pointer] <= shreg;
      if (av_reg_wr) bank[bus.address[3:0]] <= bus.writedata[7:0];
      wr_event     <= byte_we  | (wr_event  & ~(av_stat_wr & bus.writedata[1]));
      nack_seen    <= nack_set | (nack_seen & ~(av_stat_wr & bus.writedata[2]));
      read_latency <= bus.read & ~read_latency;
      if (bus.read & ~read_latency) readdata <= rd_mux;
    end
  end

  assign bus.readdata    = readdata;
  assign bus.waitrequest = bus.read & ~read_latency;
  assign unused_wdata    = ^bus.writedata[31:8];
endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: bit-banged I2C master plus Avalon master, checked
// against a transaction-level model of the bank, pointer and sticky bits.
module tb_i2c_slave_regs;
  localparam int Q = 8;

  logic clock = 1'b0;
  logic clock_sreset = 1'b1;
  logic sda_m = 1'b1, scl_m = 1'b1;
  wire  sda, scl;
  pullup (sda);
  pullup (scl);
  assign sda = sda_m ? 1'bz : 1'b0;
  assign scl = scl_m ? 1'bz : 1'b0;

  i2c_slave_regs_if bus();
  i2c_slave_regs #(.SLAVE_ADDR(7'h42), .FILTER_LEN(3)) dut (
    .clock(clock), .clock_sreset(clock_sreset), .bus(bus), .sda(sda), .scl(scl));

  always #10 clock = ~clock;

  int total = 0, bad = 0;
  logic [7:0] bank_m [16];
  logic [3:0] ptr_m;
  logic       wr_m, nack_m;
  logic [7:0] byte_q [$];
  bit         low_seen;

  always @(negedge clock) if (sda_m && sda === 1'b0) low_seen = 1'b1;

  initial begin
    #1_800_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) bank_m[i] = 8'h00;
    ptr_m = 4'd0; wr_m = 1'b0; nack_m = 1'b0;
  endtask

  task automatic av_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clock);
    bus.address = a; bus.writedata = d; bus.write = 1'b1;
    @(negedge clock);
    bus.write = 1'b0;
    if (a < 5'd16) bank_m[a[3:0]] = d[7:0];
    if (a == 5'd16) begin
      if (d[1]) wr_m = 1'b0;
      if (d[2]) nack_m = 1'b0;
    end
  endtask

  task automatic av_read(input logic [4:0] a, output logic [31:0] d);
    int n;
    @(negedge clock);
    bus.address = a; bus.read = 1'b1;
    #1;
    n = 0;
    while (bus.waitrequest && n < 10) begin
      @(negedge clock); #1; n++;
    end
    d = bus.readdata;
    bus.read = 1'b0;
    chk("rd_stall", n, 1);
  endtask

  task automatic chk_status(input string tag, input logic busy);
    logic [31:0] rd;
    av_read(5'd16, rd);
    chk(tag, rd, {29'b0, nack_m, wr_m, busy});
  endtask

  task automatic chk_bank();
    logic [31:0] rd;
    for (int i = 0; i < 16; i++) begin
      av_read(5'(i), rd);
      chk($sformatf("bank%0d", i), rd, {24'b0, bank_m[i]});
    end
  endtask

  task automatic i2c_bit(input logic b, output logic s, input bit glitch);
    hold(Q); sda_m = b; hold(Q); scl_m = 1'b1; hold(Q);
    if (glitch) begin scl_m = 1'b0; hold(1); scl_m = 1'b1; end
    s = sda; hold(Q); scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; hold(Q); scl_m = 1'b1; hold(Q); sda_m = 1'b0; hold(Q); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    hold(Q); sda_m = 1'b0; hold(Q); scl_m = 1'b1; hold(Q); sda_m = 1'b1; hold(Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack, input int glitch_at);
    logic s;
    for (int i = 7; i >= 0; i--) i2c_bit(d[i], s, glitch_at == i);
    i2c_bit(1'b1, s, 1'b0);
    ack = ~s;
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] d);
    logic s;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      i2c_bit(1'b1, s, 1'b0);
      d = {d[6:0], s};
    end
    i2c_bit(nack, s, 1'b0);
  endtask

  task automatic send_ptr(input logic [3:0] p);
    logic [7:0] v;
    logic ack;
    v = 8'($urandom);
    v[3:0] = p;
    wr_byte(v, ack, -1);
    chk("ptr_ack", ack, 1);
    ptr_m = p;
  endtask

  // Write every byte in byte_q starting at entry p.
  task automatic i2c_write(input logic [3:0] p);
    logic ack;
    i2c_start();
    wr_byte(8'h84, ack, -1);
    chk("addr_w_ack", ack, 1);
    chk_status("busy_mid", 1'b1);
    send_ptr(p);
    foreach (byte_q[k]) begin
      wr_byte(byte_q[k], ack, -1);
      chk("data_ack", ack, 1);
      bank_m[ptr_m] = byte_q[k];
      ptr_m = ptr_m + 4'd1;
      wr_m = 1'b1;
    end
    i2c_stop();
  endtask

  // Set the pointer, repeated START, then read n bytes with a NACK on the last.
  task automatic i2c_read(input logic [3:0] p, input int n);
    logic ack;
    logic [7:0] d;
    i2c_start();
    wr_byte(8'h84, ack, -1);
    chk("addr_w_ack", ack, 1);
    send_ptr(p);
    i2c_start();
    wr_byte(8'h85, ack, -1);
    chk("addr_r_ack", ack, 1);
    for (int k = 0; k < n; k++) begin
      rd_byte(k == n - 1, d);
      chk($sformatf("rd_byte%0d", k), d, bank_m[ptr_m]);
      ptr_m = ptr_m + 4'd1;
    end
    nack_m = 1'b1;
    i2c_stop();
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  v;
    logic [3:0]  p;
    logic        ack;
    logic        s;
    bus.address = '0; bus.writedata = '0; bus.read = 1'b0; bus.write = 1'b0;
    model_reset();
    hold(3);
    clock_sreset = 1'b0;
    hold(1);
    chk("rst_rdata", bus.readdata, 0);
    chk("rst_wait", bus.waitrequest, 0);
    chk("rst_sda", sda, 1);
    chk_status("rst_status", 1'b0);
    chk_bank();

    av_write(5'd3, 32'hFFFF_FFA5);
    av_read(5'd3, rd);
    chk("av_rw", rd, 32'h0000_00A5);

    byte_q = '{8'h11, 8'h22, 8'h33};
    i2c_write(4'hE);
    chk_status("status_after_wr", 1'b0);
    chk_bank();

    i2c_read(4'h3, 2);
    chk_status("status_after_rd", 1'b0);
    av_write(5'd16, 32'h6);
    chk_status("status_w1c", 1'b0);

    low_seen = 1'b0;
    i2c_start();
    wr_byte(8'h90, ack, -1);
    chk("foreign_nack", ack, 0);
    chk_status("foreign_busy", 1'b0);
    wr_byte(8'hFF, ack, -1);
    i2c_stop();
    chk("foreign_sda_low", low_seen, 0);
    chk_bank();

    // SCL glitches inside the pointer and data bytes must not add bits.
    i2c_start();
    wr_byte(8'h84, ack, 5);
    chk("glitch_addr_ack", ack, 1);
    wr_byte(8'h07, ack, 3);
    chk("glitch_ptr_ack", ack, 1);
    v = 8'($urandom);
    wr_byte(v, ack, 0);
    chk("glitch_data_ack", ack, 1);
    i2c_stop();
    bank_m[7] = v; ptr_m = 4'd8; wr_m = 1'b1;
    chk_bank();

    for (int it = 0; it < 8; it++) begin
      byte_q.delete();
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) byte_q.push_back(8'($urandom));
      i2c_write(4'($urandom));
      av_write(5'($urandom), $urandom);
      av_read(5'($urandom_range(17, 31)), rd);
      chk("hi_addr", rd, 0);
      i2c_read(4'($urandom), $urandom_range(1, 3));
      chk_status("rand_status", 1'b0);
    end
    chk_bank();

    // Reset while the DUT is driving bit 4 (forced to 0) of a read byte.
    p = 4'($urandom);
    v = 8'($urandom) & 8'hEF;
    av_write({1'b0, p}, {24'b0, v});
    i2c_start();
    wr_byte(8'h84, ack, -1);
    send_ptr(p);
    i2c_start();
    wr_byte(8'h85, ack, -1);
    chk("addr_r_ack2", ack, 1);
    for (int i = 0; i < 3; i++) i2c_bit(1'b1, s, 1'b0);
    hold(Q); sda_m = 1'b1; hold(Q); scl_m = 1'b1; hold(Q);
    chk("bit4_driven", sda, 0);
    clock_sreset = 1'b1;
    hold(1);
    clock_sreset = 1'b0;
    chk("rst_sda_release", sda, 1);
    model_reset();
    hold(Q);
    chk_status("rst_mid_status", 1'b0);
    byte_q = '{8'($urandom), 8'($urandom)};
    i2c_write(4'($urandom));
    chk_status("post_rst_status", 1'b0);
    chk_bank();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/i2c_slave_regs.md
Name: i2c_slave_regs

Overview:
- I2C target (responder) that answers an external I2C master at a fixed 7-bit address.
- Exposes a 16 x 8-bit register bank: the I2C master reaches it over SDA/SCL, and the local CPU reaches it over an Avalon-MM slave port.
- Standard/fast mode, no clock stretching. The block only ever pulls SDA low and never drives SCL.

Parameters:
- SLAVE_ADDR, 7'h42, 7-bit I2C address the block acknowledges.
- FILTER_LEN, 3, number of consecutive equal synchronized samples required before SCL/SDA levels are accepted (glitch filter).

Ports:
- clock  in  1  system clock, 50 MHz typical.
- clock_sreset  in  1  reset; one clock; synchronous, active-high.
- address  in  5  Avalon word address: 0-15 select register bank entries; 16 selects STATUS.
- readdata  out  32  Avalon read data; {24'b0, byte} or the STATUS value.
- writedata  in  32  Avalon write data; bits [7:0] are used.
- read  in  1  Avalon read strobe.
- write  in  1  Avalon write strobe.
- waitrequest  out  1  Avalon stall.
- sda  inout  1  open-drain I2C data; driven only as 0 or z.
- scl  inout  1  I2C clock input; this block never drives it (always z).

Behaviour:
- Reset values:
  - readdata = 0; register bank = 0; STATUS = 0.
  - pointer = 0; FSM = IDLE; SDA released (z).
  - Reset mid-transfer aborts the transfer immediately and releases SDA.
- Input conditioning:
  - SCL and SDA each pass through a 2-FF synchronizer, then the FILTER_LEN filter.
  - Edges are detected on the filtered levels.
- Bus events (filtered levels):
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Bit timing: data is sampled on the SCL rising edge; SDA drive changes only on the SCL falling edge.
  - START from any state, including a repeated START, goes to ADDR with bit count 0.
  - STOP from any state releases SDA and goes to IDLE.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
  - ADDR: shift in 8 bits, MSB first.
    - If the 7-bit address equals SLAVE_ADDR: drive SDA low after the 8th falling edge and go to ADDR_ACK.
    - Otherwise go to IGNORE and do not drive SDA until the next START or STOP.
  - ADDR_ACK:
    - R/W = 0 (write): release SDA on the next falling edge and go to PTR.
    - R/W = 1 (read): on the next falling edge load shift register = bank[pointer], drive the MSB, and go to RDATA.
  - PTR: receive 8 bits; bits [3:0] load the pointer and bits [7:4] are ignored. Then ACK (PTR_ACK) and go to WDATA.
  - WDATA: receive 8 bits; write bank[pointer]; pointer += 1, wrapping 15 to 0. Then ACK (WDATA_ACK) and return to WDATA.
  - RDATA: drive 8 bits MSB first, changing on falling edges. After the 8th falling edge release SDA and go to RDATA_ACK.
    - Each read byte advances the pointer by 1, wrapping 15 to 0.
  - RDATA_ACK: sample SDA on the SCL rising edge.
    - 0 (ACK): on the next falling edge load bank[pointer] and go to RDATA.
    - 1 (NACK): go to IGNORE with SDA released.
- Avalon side:
  - waitrequest = read & ~read_latency, where read_latency is a one-cycle pulse registered from read, so every read stalls exactly 1 cycle. Writes never stall.
  - Read of address 0-15 returns {24'b0, bank[address]}.
  - Read of address 16 returns STATUS = {29'b0, nack_seen, wr_event, busy}.
    - busy = 1 while the FSM is not IDLE or IGNORE.
    - wr_event (sticky) is set when an I2C data byte is written to the bank.
    - nack_seen (sticky) is set when the master NACKs a read byte.
  - Write to address 0-15 stores writedata[7:0].
  - Write to address 16 is write-1-to-clear for bits [2:1].
  - Addresses 17-31: reads return 0; writes are ignored.
- Collisions:
  - An Avalon write and an I2C write to the same entry in the same cycle: the Avalon value is stored.
  - A sticky-bit set and a W1C clear in the same cycle: the set wins.
  - An I2C read loads the shift register at the falling edge, so a later Avalon write does not change the byte in flight.

Test Plan:
- Reset, then Avalon write 0xA5 to address 3; read address 3 -> waitrequest high 1 cycle, readdata = 0x000000A5.
- I2C START, 0x84 (0x42 write), ptr 0x0E, data 0x11, 0x22, 0x33, STOP -> ACK on all 5 bytes; bank[14]=0x11, bank[15]=0x22, bank[0]=0x33 (wrap); STATUS = 0x2 after STOP.
- I2C START, 0x84, ptr 0x03, repeated START, 0x85, read 2 bytes (ACK then NACK), STOP -> SDA shows 0xA5 then bank[4]; STATUS bit2 = 1; Avalon write 0x6 to address 16 -> STATUS = 0x0.
- I2C START, 0x90 (address 0x48), data 0xFF, STOP -> SDA never driven low; bank unchanged; busy stays 0.
- 1-cycle glitch on SCL while SCL is high with FILTER_LEN=3 -> no bit shifted; a subsequent byte is received correctly.
- Assert clock_sreset during the 4th bit of a read byte -> SDA released the next cycle; FSM = IDLE; the next full write transaction completes normally.
